uart_collector: RTL and testbench

//  UART receiver that turns an asynchronous 8N1 serial line into an AXI-Stream byte stream
//  (o_tdata/o_tlast/o_tvalid/i_tready), the receive-side counterpart of emitter.

---
 rtl/uart_collector_pkg.sv | 19 +
 rtl/uart_collector_fifo.sv | 78 +++++++
 rtl/uart_collector.sv | 175 +++++++++++++++++
 tb/tb_uart_collector.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_collector_pkg.sv
// Shared constants for the UART receive path: FSM state encodings,
// the end-of-line byte and the clocks-per-bit rounding rule.
package uart_collector_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam logic [7:0] NEWLINE = 8'h0A;

  // Round-to-nearest division so the bit period error stays under half a clock.
  function automatic int unsigned clks_per_bit(input int unsigned freq_hz,
                                               input int unsigned baud);
    return (freq_hz + (baud / 32'd2)) / baud;
  endfunction

endpackage

// File: rtl/uart_collector_fifo.sv
// First-word-fall-through FIFO holding {tlast, tdata} entries.
// The head entry is visible on o_dout whenever the FIFO is not empty;
// o_dout is forced to zero while empty so the stream outputs idle at 0.
module uart_collector_fifo #(
  parameter int aw = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [8:0] i_din,
  input  logic       i_pop,
  output logic [8:0] o_dout,
  output logic       o_empty,
  output logic       o_accept
);

  localparam int DEPTH = 1 << aw;
  localparam logic [aw:0] CNT_FULL = {1'b1, {aw{1'b0}}};

  logic [8:0]    mem [0:DEPTH-1];
  logic [aw-1:0] wr_q, wr_d;
  logic [aw-1:0] rd_q, rd_d;
  logic [aw:0]   cnt_q, cnt_d;
  logic          full_s;
  logic          do_pop_s;
  logic          do_push_s;

  assign full_s    = (cnt_q == CNT_FULL);
  assign o_empty   = (cnt_q == {(aw+1){1'b0}});
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign do_pop_s  = i_pop & ~o_empty;
  assign do_push_s = i_push & (~full_s | do_pop_s);
  assign o_accept  = do_push_s;
  assign o_dout    = o_empty ? 9'h000 : mem[rd_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push_s) begin
      wr_d = wr_q + aw'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + aw'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + (aw+1)'(1);
      2'b01:   cnt_d = cnt_q - (aw+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q  <= {aw{1'b0}};
      rd_q  <= {aw{1'b0}};
      cnt_q <= {(aw+1){1'b0}};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset because o_dout is masked while empty.
  always_ff @(posedge i_clk) begin
    if (do_push_s) begin
      mem[wr_q] <= i_din;
    end
  end

endmodule

// File: rtl/uart_collector.sv
// 8N1 UART receiver feeding an AXI-Stream byte interface through a small
// FWFT FIFO. o_tlast flags a newline byte. The serial side never stalls:
// a byte arriving at a full FIFO is dropped and reported on o_overrun.
module uart_collector
  import uart_collector_pkg::*;
#(
  parameter int unsigned clk_freq_hz = 32'd16000000,
  parameter int unsigned baud_rate   = 32'd57600,
  parameter int          fifo_aw     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned CPB = clks_per_bit(clk_freq_hz, baud_rate);
  localparam int          CW  = $clog2(CPB + 32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 32'd1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CPB / 32'd2) - 32'd1);

  logic          sync1_q, sync2_q;
  logic          rx_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic [7:0]    push_data_q, push_data_d;
  logic          push_last_q, push_last_d;
  logic          ferr_q, ferr_d;
  logic [8:0]    head_s;
  logic          empty_s;
  logic          accept_s;
  logic          pop_s;

  assign rx_s = sync2_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
    end
  end

  // Receiver FSM: start qualification at half bit, then mid-bit sampling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    push_last_d = push_last_q;
    ferr_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_s == 1'b0) begin
          state_d = ST_START;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = {CW{1'b0}};
          idx_d = 3'd0;
          // A line that is high again at mid start bit was only a glitch.
          if (rx_s == 1'b1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = {CW{1'b0}};
          if (rx_s == 1'b1) begin
            push_d      = 1'b1;
            push_data_d = shift_q;
            push_last_d = (shift_q == NEWLINE);
            state_d     = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_BREAK: begin
        // Hold off start detection until the line has returned to idle.
        if (rx_s == 1'b1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Receiver state and registered push/error strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      push_q      <= 1'b0;
      push_data_q <= 8'h00;
      push_last_q <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      push_last_q <= push_last_d;
      ferr_q      <= ferr_d;
    end
  end

  uart_collector_fifo #(
    .aw(fifo_aw)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_q),
    .i_din   ({push_last_q, push_data_q}),
    .i_pop   (pop_s),
    .o_dout  (head_s),
    .o_empty (empty_s),
    .o_accept(accept_s)
  );

  assign o_tvalid    = ~empty_s;
  assign pop_s       = ~empty_s & i_tready;
  assign o_tdata     = head_s[7:0];
  assign o_tlast     = head_s[8];
  assign o_frame_err = ferr_q;
  // Overrun is flagged in the push cycle itself, when the FIFO refuses the byte.
  assign o_overrun   = push_q & ~accept_s;

endmodule

// File: tb/tb_uart_collector.sv
// Directed + randomized bench for uart_collector (CLKS_PER_BIT = 10, 4-deep FIFO).
// Expected beats come from a byte-level model: good frames yield their byte,
// tlast is (byte == 8'h0A), and a stalled consumer keeps at most 4 bytes.
module tb_uart_collector;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_uart_rx;
  logic [7:0] o_tdata;
  logic       o_tlast;
  logic       o_tvalid;
  logic       i_tready;
  logic       o_frame_err;
  logic       o_overrun;

  int checks   = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [8:0] got   [$];
  logic [7:0] exp_q [$];

  uart_collector #(
    .clk_freq_hz(32'd1000000),
    .baud_rate  (32'd100000),
    .fifo_aw    (2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_uart_rx  (i_uart_rx),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .i_tready   (i_tready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  always #5 clk = ~clk;

  // Stream monitor: records accepted beats and counts error pulses.
  always @(negedge clk) begin
    if (o_tvalid && i_tready) got.push_back({o_tlast, o_tdata});
    if (o_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (o_overrun) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serialises one frame; a low stop bit is held for stop_len cycles then released.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_len);
    i_uart_rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = d[i];
      hold(CPB);
    end
    i_uart_rx = stop_lvl;
    hold(stop_len);
    i_uart_rx = 1'b1;
    if (!stop_lvl) hold(CPB);
  endtask

  task automatic check_beats(input string tag, input int base);
    chk({tag, "_count"}, 32'(got.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got.size()) begin
        chk({tag, "_data"}, 32'(got[base+i][7:0]), 32'(exp_q[i]));
        chk({tag, "_last"}, 32'(got[base+i][8]), 32'(exp_q[i] == 8'h0A));
      end
    end
  endtask

  initial begin
    int base;
    int fe0;
    int ov0;
    int lat;
    logic seen;
    logic [7:0] b;
    logic [7:0] t1_byte;

    i_rst = 1'b1;
    i_uart_rx = 1'b1;
    i_tready = 1'b1;
    hold(3);
    chk("rst_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_tlast", 32'(o_tlast), 32'd0);
    chk("rst_tdata", 32'(o_tdata), 32'd0);
    chk("rst_frame_err", 32'(o_frame_err), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    i_rst = 1'b0;
    hold(5);

    // 1: single byte, latency from stop-bit edge and one-cycle beat
    t1_byte = 8'h55;
    i_uart_rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = t1_byte[i];
      hold(CPB);
    end
    i_uart_rx = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (o_tvalid) seen = 1'b1;
    end
    chk("t1_tvalid_seen", 32'(seen), 32'd1);
    // 5 cycles to stop midpoint + 2 sync + 1 push, within +/-1
    chk("t1_latency", (lat >= 7 && lat <= 9) ? 32'd8 : 32'(lat), 32'd8);
    chk("t1_tdata", 32'(o_tdata), 32'h55);
    chk("t1_tlast", 32'(o_tlast), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_one_cycle", 32'(o_tvalid), 32'd0);
    hold(CPB);

    // 2: "Hi\n" back-to-back followed by random bytes, consumer always ready
    base = got.size();
    exp_q = {8'h48, 8'h69, 8'h0A};
    for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < exp_q.size(); i++) send_frame(exp_q[i], 1'b1, CPB);
    hold(20);
    check_beats("t2_stream", base);

    // 3: consumer stalled, fifth byte overruns the 4-deep FIFO
    i_tready = 1'b0;
    base = got.size();
    ov0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, CPB);
    hold(20);
    chk("t3_tvalid_held", 32'(o_tvalid), 32'd1);
    chk("t3_head_stable", 32'(o_tdata), 32'h01);
    chk("t3_overrun_pulses", 32'(ovr_cnt - ov0), 32'd1);
    exp_q = {};
    for (int i = 1; i <= 5; i++) if (i <= DEPTH) exp_q.push_back(8'(i));
    i_tready = 1'b1;
    hold(10);
    check_beats("t3_drain", base);
    chk("t3_empty_after", 32'(o_tvalid), 32'd0);

    // 4: stop bit held low -> one frame error, then a clean byte
    base = got.size();
    fe0 = ferr_cnt;
    send_frame(8'hA5, 1'b0, 30);
    send_frame(8'h3C, 1'b1, CPB);
    hold(20);
    chk("t4_frame_err_pulses", 32'(ferr_cnt - fe0), 32'd1);
    exp_q = {8'h3C};
    check_beats("t4_after_break", base);

    // 4b: random mix of good frames and frames with a low stop bit
    base = got.size();
    fe0 = ferr_cnt;
    exp_q = {};
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        send_frame(b, 1'b1, CPB);
        exp_q.push_back(b);
      end else begin
        send_frame(b, 1'b0, 15);
        lat++;
      end
    end
    hold(20);
    chk("t4b_frame_errs", 32'(ferr_cnt - fe0), 32'(lat));
    check_beats("t4b_mix", base);

    // 5: 3-cycle glitch on the idle line, then a byte to prove the FSM is idle
    base = got.size();
    fe0 = ferr_cnt;
    ov0 = ovr_cnt;
    i_uart_rx = 1'b0;
    hold(3);
    i_uart_rx = 1'b1;
    hold(30);
    chk("t5_no_beat", 32'(got.size() - base), 32'd0);
    chk("t5_no_ferr", 32'(ferr_cnt - fe0), 32'd0);
    chk("t5_no_overrun", 32'(ovr_cnt - ov0), 32'd0);
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, CPB);
    hold(20);
    exp_q = {b};
    check_beats("t5_after_glitch", base);

    // 6: reset mid-DATA with two bytes queued
    i_tready = 1'b0;
    send_frame(8'($urandom_range(0, 255)), 1'b1, CPB);
    send_frame(8'($urandom_range(0, 255)), 1'b1, CPB);
    hold(15);
    chk("t6_queued", 32'(o_tvalid), 32'd1);
    i_uart_rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 3; i++) begin
      i_uart_rx = 1'(i & 1);
      hold(CPB);
    end
    i_rst = 1'b1;
    hold(1);
    chk("t6_tvalid_after_rst", 32'(o_tvalid), 32'd0);
    chk("t6_tdata_after_rst", 32'(o_tdata), 32'd0);
    i_rst = 1'b0;
    i_uart_rx = 1'b1;
    hold(20);
    chk("t6_still_empty", 32'(o_tvalid), 32'd0);
    i_tready = 1'b1;
    base = got.size();
    send_frame(8'h7E, 1'b1, CPB);
    hold(20);
    exp_q = {8'h7E};
    check_beats("t6_after_rst", base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
